// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: read pointer, Gray pointer export,
// write-pointer synchroniser and registered empty / almost-empty / level / underflow.
module async_fifo_rd_ctrl #(
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 4
) (
  input  logic              r_clk,
  input  logic              r_reset,
  input  logic              r_en,
  input  logic [ADDR_W:0]   w_ptr_gray,
  output logic [ADDR_W-1:0] r_addr,
  output logic [ADDR_W:0]   r_ptr_gray,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   r_level,
  output logic              underflow
);

  localparam int PW = ADDR_W + 1;
  localparam logic [ADDR_W:0] AE_LIM = PW'(AE_THRESH);

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [ADDR_W:0] r_bin;
  logic [ADDR_W:0] r_sync [SYNC_STAGES];

  logic            w_rd_ok;
  logic [ADDR_W:0] w_bin_next;
  logic [ADDR_W:0] w_gray_next;
  logic [ADDR_W:0] w_wq;
  logic [ADDR_W:0] w_bin_s;
  logic [ADDR_W:0] w_level_next;

  assign w_rd_ok      = r_en & ~empty;
  assign w_bin_next   = r_bin + {{ADDR_W{1'b0}}, w_rd_ok};
  assign w_gray_next  = bin2gray(w_bin_next);
  assign w_wq         = r_sync[SYNC_STAGES-1];
  assign w_bin_s      = gray2bin(w_wq);
  // Status is judged against the post-read pointer so a read is reflected at once.
  assign w_level_next = w_bin_s - w_bin_next;

  always_ff @(posedge r_clk or posedge r_reset) begin
    if (r_reset) begin
      r_bin        <= '0;
      r_ptr_gray   <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      r_level      <= '0;
      underflow    <= 1'b0;
    end else begin
      r_bin        <= w_bin_next;
      r_ptr_gray   <= w_gray_next;
      r_sync[0]    <= w_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      empty        <= (w_gray_next == w_wq);
      almost_empty <= (w_level_next <= AE_LIM);
      r_level      <= w_level_next;
      underflow    <= r_en & empty;
    end
  end

  assign r_addr = r_bin[ADDR_W-1:0];

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed bench for async_fifo_rd_ctrl: count-based model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_async_fifo_rd_ctrl;

  localparam int AW   = 5;
  localparam int SS   = 2;
  localparam int AE   = 4;
  localparam int MODP = 64;

  logic          r_clk;
  logic          r_reset;
  logic          r_en;
  logic [AW:0]   w_ptr_gray;
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_ptr_gray;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   r_level;
  logic          underflow;

  async_fifo_rd_ctrl #(.ADDR_W(AW), .SYNC_STAGES(SS), .AE_THRESH(AE)) dut (
    .r_clk(r_clk), .r_reset(r_reset), .r_en(r_en), .w_ptr_gray(w_ptr_gray),
    .r_addr(r_addr), .r_ptr_gray(r_ptr_gray), .empty(empty),
    .almost_empty(almost_empty), .r_level(r_level), .underflow(underflow)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  int errors = 0;
  int checks = 0;

  // Model state: counts of entries written (as driven) and read, plus the
  // delay line that says which write count the read side can see.
  int wcnt;
  int rcnt;
  int dq[$];
  int m_level;
  bit m_empty;
  bit m_ae;
  bit m_uf;
  int prev_gray;

  function automatic logic [AW:0] to_gray(input int v);
    int g;
    g = (v ^ (v >> 1)) & (MODP - 1);
    return g[AW:0];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rcnt = 0;
    dq = {};
    repeat (SS) dq.push_back(0);
    m_level = 0;
    m_empty = 1'b1;
    m_ae = 1'b1;
    m_uf = 1'b0;
    prev_gray = 0;
  endtask

  task automatic compare(input string tag);
    int cur_gray;
    int exp_gray;
    cur_gray = int'(r_ptr_gray);
    exp_gray = int'(to_gray(rcnt));
    chk({tag, ".empty"}, int'(empty), int'(m_empty));
    chk({tag, ".almost_empty"}, int'(almost_empty), int'(m_ae));
    chk({tag, ".r_level"}, int'(r_level), m_level);
    chk({tag, ".underflow"}, int'(underflow), int'(m_uf));
    chk({tag, ".r_addr"}, int'(r_addr), rcnt % 32);
    chk({tag, ".r_ptr_gray"}, cur_gray, exp_gray);
    chk({tag, ".gray_one_bit"}, int'($countones(cur_gray ^ prev_gray) <= 1), 1);
    prev_gray = cur_gray;
  endtask

  task automatic cycle(input logic en);
    int ok;
    int wq;
    r_en = en;
    w_ptr_gray = to_gray(wcnt);
    @(posedge r_clk);
    ok = (en && !m_empty) ? 1 : 0;
    m_uf = en && m_empty;
    rcnt = (rcnt + ok) % MODP;
    wq = dq.pop_front();
    dq.push_back(wcnt);
    m_level = (wq - rcnt) & (MODP - 1);
    m_empty = (m_level == 0);
    m_ae = (m_level <= AE);
    #1;
    compare("cyc");
  endtask

  // Reset asserted between clock edges, held across one edge, released mid-cycle.
  task automatic do_reset();
    #3;
    r_reset = 1'b1;
    r_en = 1'b0;
    wcnt = 0;
    w_ptr_gray = '0;
    #1;
    model_reset();
    compare("rst_async");
    @(posedge r_clk);
    #1;
    compare("rst_hold");
    #4;
    r_reset = 1'b0;
  endtask

  initial begin
    r_reset = 1'b0;
    r_en = 1'b0;
    w_ptr_gray = '0;
    wcnt = 0;
    model_reset();

    do_reset();
    chk("lit.reset_empty", int'(empty), 1);
    chk("lit.reset_level", int'(r_level), 0);

    // Fill visibility: first write shows up after the third edge.
    wcnt = 1;
    cycle(1'b0);
    chk("lit.fill_k_empty", int'(empty), 1);
    cycle(1'b0);
    chk("lit.fill_k1_empty", int'(empty), 1);
    cycle(1'b0);
    chk("lit.fill_k2_empty", int'(empty), 0);
    chk("lit.fill_k2_level", int'(r_level), 1);
    chk("lit.fill_k2_ae", int'(almost_empty), 1);
    for (int v = 2; v <= 5; v++) begin
      wcnt = v;
      cycle(1'b0);
    end
    cycle(1'b0);
    cycle(1'b0);
    chk("lit.fill5_level", int'(r_level), 5);
    chk("lit.fill5_ae", int'(almost_empty), 0);

    // Read seven entries, then reset mid-operation.
    wcnt = 7;
    repeat (3) cycle(1'b0);
    repeat (7) cycle(1'b1);
    chk("lit.pre_reset_addr", int'(r_addr), 7);
    chk("lit.pre_reset_empty", int'(empty), 1);
    do_reset();
    chk("lit.post_reset_addr", int'(r_addr), 0);
    chk("lit.post_reset_gray", int'(r_ptr_gray), 0);

    // Drain: three entries, five requests.
    wcnt = 3;
    repeat (3) cycle(1'b0);
    chk("lit.drain_addr0", int'(r_addr), 0);
    cycle(1'b1);
    chk("lit.drain_addr1", int'(r_addr), 1);
    cycle(1'b1);
    chk("lit.drain_addr2", int'(r_addr), 2);
    cycle(1'b1);
    chk("lit.drain_empty3", int'(empty), 1);
    chk("lit.drain_uf3", int'(underflow), 0);
    cycle(1'b1);
    chk("lit.drain_uf4", int'(underflow), 1);
    cycle(1'b1);
    chk("lit.drain_uf5", int'(underflow), 1);
    chk("lit.drain_addr5", int'(r_addr), 3);
    cycle(1'b0);
    chk("lit.drain_uf_idle", int'(underflow), 0);

    // Full level of 32 entries, then read all of them.
    do_reset();
    wcnt = 32;
    repeat (3) cycle(1'b0);
    chk("lit.full_level", int'(r_level), 32);
    chk("lit.full_empty", int'(empty), 0);
    repeat (32) cycle(1'b1);
    chk("lit.full_drained_empty", int'(empty), 1);
    chk("lit.full_drained_gray", int'(r_ptr_gray), 48);
    chk("lit.full_drained_addr", int'(r_addr), 0);

    // Wrap-around: write and read every cycle.
    for (int n = 0; n < 70; n++) begin
      wcnt = (wcnt + 1) % MODP;
      cycle(1'b1);
    end
    repeat (3) cycle(1'b0);
    repeat (5) cycle(1'b1);
    chk("lit.wrap_empty", int'(empty), 1);
    chk("lit.wrap_addr", int'(r_addr), 6);
    chk("lit.wrap_gray", int'(r_ptr_gray), 53);

    // Simultaneous read and write-pointer arrival at the same edge.
    do_reset();
    wcnt = 1;
    repeat (3) cycle(1'b0);
    wcnt = 2;
    cycle(1'b0);
    cycle(1'b0);
    chk("lit.simul_pre_level", int'(r_level), 1);
    cycle(1'b1);
    chk("lit.simul_level", int'(r_level), 1);
    chk("lit.simul_empty", int'(empty), 0);
    cycle(1'b0);
    chk("lit.simul_after_level", int'(r_level), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/async_fifo_rd_ctrl.md
# async_fifo_rd_ctrl

Parametrised read-side controller for the asynchronous FIFO. It owns the read pointer and publishes a registered Gray-coded copy to the write domain. It also synchronises the write domain's Gray pointer into r_clk and derives registered empty, almost-empty, fill level and underflow status. It sits between the FIFO memory read port and the write-side controller.

## Interface
- ADDR_W, 5, memory address width; depth = 2^ADDR_W; pointers are ADDR_W+1 bits (extra wrap bit)
- SYNC_STAGES, 2, flops in w_ptr_gray synchroniser (legal ≥ 2)
- AE_THRESH, 4, almost_empty asserts when level ≤ AE_THRESH (legal 0..2^ADDR_W)
- r_clk  in  1  read-domain clock
- r_reset  in  1  reset, asynchronous, active-high
- r_en  in  1  read request; accepted only when empty=0
- w_ptr_gray  in  ADDR_W+1  write pointer, Gray, from write domain (asynchronous to r_clk)
- r_addr  out  ADDR_W  memory read address = r_bin[ADDR_W-1:0]
- r_ptr_gray  out  ADDR_W+1  registered Gray read pointer to write domain
- empty  out  1  registered; 1 = no readable entry
- almost_empty  out  1  registered; 1 = level ≤ AE_THRESH
- r_level  out  ADDR_W+1  registered entry count as seen in read domain, 0..2^ADDR_W
- underflow  out  1  registered one-cycle pulse: r_en was high while empty=1

## Operation
- State: r_bin (ADDR_W+1 binary), r_ptr_gray, sync chain sync[0..SYNC_STAGES-1], empty, almost_empty, r_level, underflow.
- Accept: rd_ok = r_en & ~empty. r_bin_next = r_bin + rd_ok, modulo 2^(ADDR_W+1); natural wrap from all-ones to 0, no special case.
- r_ptr_gray <= bin2gray(r_bin_next) every cycle, not gated by r_en. It changes at most one bit per edge.
- Synchroniser: sync[0] <= w_ptr_gray, sync[i] <= sync[i-1]. wq = sync[SYNC_STAGES-1]. w_bin_s = gray2bin(wq). No logic between sync stages.
- empty <= (bin2gray(r_bin_next) == wq).
- r_level <= (w_bin_s − r_bin_next) mod 2^(ADDR_W+1).
- almost_empty <= (that same level value ≤ AE_THRESH).
- underflow <= r_en & empty. The pointer never moves on an underflow attempt.
- Full/empty are distinguished by the wrap bit. A level of 2^ADDR_W (wrap bits differ, lower bits equal) is legal and reported as-is.
- Status is pessimistic: writes become visible late, reads are reflected immediately. empty never deasserts early.

## Timing
- Reset (async assert, sync release): r_bin=0, r_addr=0, r_ptr_gray=0, sync chain=0, empty=1, almost_empty=1, r_level=0, underflow=0.
- Read latency: with r_en=1 and empty=0 sampled at edge N, r_addr/r_ptr_gray advance after edge N. The memory supplies data for the old r_addr during cycle N.
- Write visibility: a change on w_ptr_gray before edge k is reflected in empty/r_level/almost_empty after edge k+SYNC_STAGES (SYNC_STAGES+1 edges).
- Read-out to empty: the read consuming the last visible entry at edge N sets empty=1 after the same edge N. No extra read is accepted.
- Simultaneous read and write-pointer arrival in the same edge: both are applied, so the level is unchanged and empty is evaluated on the new values.
- Reset mid-operation: all state clears immediately, regardless of r_clk. The sync chain restarts from 0, and the write side is reset together by system convention.
- Back-to-back reads: one entry per cycle at full rate while empty=0.

## Test plan
- Reset: assert r_reset mid-cycle with r_bin=7 -> all outputs return to reset values at once; empty=1, r_level=0.
- Fill visibility (ADDR_W=5, SYNC=2): w_ptr_gray 0→1 before edge k -> empty falls after edge k+2, r_level=1, almost_empty=1. Steps 1..5 -> almost_empty=0 once r_level=5.
- Drain: 3 entries visible, r_en held high 5 cycles -> r_addr 0,1,2,3,3; empty rises after 3rd accepting edge; underflow pulses on the cycles following the 4th and 5th requests; r_bin stays 3.
- Full level: write pointer gray(32) with r_bin=0 -> r_level=32, empty=0. Read 32 -> empty=1, r_bin=32, r_ptr_gray=gray(32)=6'b110000.
- Wrap-around: 70 write/read pairs -> r_bin wraps 63→0, r_addr wraps 31→0. Every r_ptr_gray transition flips exactly one bit; empty is correct throughout.
- Simultaneous: level=1, r_en=1 at the edge where the write pointer increment lands -> r_level stays 1, empty stays 0.
